// File: rtl/collision_detector.sv
// collision_detector: reader side of the per-pixel draw-request interface.
// Accumulates ball/flipper, ball/obstacle and ball/border overlaps over one
// frame, then at the next startOfFrame emits one-cycle collision pulses and a
// hit-side code for the ball physics block. Each collision kind has a
// cooldown that suppresses repeat reports for COOLDOWN_FRAMES frames.
//
// Optional build macro COLLISION_START_GATE_EN: adds a `start` input. While
// start=0 detection is frozen (state WAIT_SOF, pulses 0, cooldowns 0).
//
// Draw interface: the object layers present pixelX/pixelY and the draw flags
// each clock; they are meaningful only when pixelValid=1. There is no
// back-pressure, so this block accepts every valid pixel in the cycle it is
// presented.
module collision_detector #(
  parameter int COORD_W         = 11,
  parameter int COOLDOWN_FRAMES = 3,
  parameter int CD_W            = 4
) (
  input  logic               clk,
  input  logic               resetN,
`ifdef COLLISION_START_GATE_EN
  input  logic               start,
`endif
  input  logic               startOfFrame,
  input  logic               pixelValid,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               draw_smiley,
  input  logic               draw_flipper,
  input  logic               drawObstacle,
  input  logic               drawBorder,
  output logic               collisionFlipper,
  output logic               collisionObstacle,
  output logic               collisionBorder,
  output logic [1:0]         hitSide,
  output logic [1:0]         state_dbg_o
);

  localparam int W1 = COORD_W + 1;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACCUM    = 2'd1,
    REPORT   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Kind index order in the packed vectors below: [2]=flipper [1]=obstacle [0]=border
  logic [COORD_W-1:0] min_x_q, max_x_q, min_y_q, max_y_q;
  logic [COORD_W-1:0] min_x_d, max_x_d, min_y_d, max_y_d;
  logic [2:0]         hit_q, hit_d;
  logic               cxv_q, cxv_d;
  logic [COORD_W-1:0] cx_q, cy_q, cx_d, cy_d;
  logic [2:0][CD_W-1:0] cd_q, cd_d;
  logic [2:0]         pulse_q, pulse_d;
  logic [1:0]         side_q, side_d;

  logic run;
  logic sof_live;
  logic close_frame;
  logic px_en;
  logic [2:0] fire;
  logic [2:0] obj_flags;

`ifdef COLLISION_START_GATE_EN
  assign run = start;
`else
  assign run = 1'b1;
`endif

  assign sof_live    = startOfFrame & run;
  // Only a SOF seen after the first one closes a real frame worth reporting.
  assign close_frame = sof_live & (state_q != WAIT_SOF);
  // The pixel sharing a cycle with SOF belongs to the new frame, so it is
  // accepted even on the SOF that leaves WAIT_SOF.
  assign px_en       = run & pixelValid & (sof_live | (state_q != WAIT_SOF));
  assign obj_flags   = {draw_flipper, drawObstacle, drawBorder};

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= WAIT_SOF;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = WAIT_SOF;
    end else begin
      case (state_q)
        WAIT_SOF: if (sof_live) state_d = ACCUM;
        ACCUM:    if (sof_live) state_d = REPORT;
        REPORT:   state_d = sof_live ? REPORT : ACCUM;
        default:  state_d = WAIT_SOF;
      endcase
    end
  end

  // Outputs: pulses are visible only during the REPORT cycle
  always_comb begin
    collisionFlipper  = run & (state_q == REPORT) & pulse_q[2];
    collisionObstacle = run & (state_q == REPORT) & pulse_q[1];
    collisionBorder   = run & (state_q == REPORT) & pulse_q[0];
    hitSide           = side_q;
    state_dbg_o       = state_q;
  end

  // Frame accumulators: clear on SOF (or while gated), then fold in this pixel
  always_comb begin
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    hit_d   = hit_q;
    cxv_d   = cxv_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (!run || sof_live) begin
      min_x_d = '1;
      max_x_d = '0;
      min_y_d = '1;
      max_y_d = '0;
      hit_d   = '0;
      cxv_d   = 1'b0;
    end
    if (px_en && draw_smiley) begin
      if (pixelX < min_x_d) min_x_d = pixelX;
      if (pixelX > max_x_d) max_x_d = pixelX;
      if (pixelY < min_y_d) min_y_d = pixelY;
      if (pixelY > max_y_d) max_y_d = pixelY;
      hit_d = hit_d | obj_flags;
      // All kinds overlapping on one pixel share that pixel as the point,
      // so flipper>obstacle>border priority gives the same (cx,cy).
      if (!cxv_d && (|obj_flags)) begin
        cxv_d = 1'b1;
        cx_d  = pixelX;
        cy_d  = pixelY;
      end
    end
  end

  // Hit-side geometry from the closing frame's box centre and collision point
  logic [W1-1:0] sum_x, sum_y, cx_c, cy_c, dx, dy, adx, ady;
  logic [1:0]    side_calc;
  always_comb begin
    sum_x = {1'b0, min_x_q} + {1'b0, max_x_q};
    sum_y = {1'b0, min_y_q} + {1'b0, max_y_q};
    cx_c  = sum_x >> 1;
    cy_c  = sum_y >> 1;
    dx    = {1'b0, cx_q} - cx_c;
    dy    = {1'b0, cy_q} - cy_c;
    adx   = dx[W1-1] ? (~dx + W1'(1)) : dx;
    ady   = dy[W1-1] ? (~dy + W1'(1)) : dy;
    if (ady >= adx) side_calc = dy[W1-1] ? 2'b00 : 2'b01;
    else            side_calc = dx[W1-1] ? 2'b10 : 2'b11;
  end

  // Report decision, cooldown bookkeeping and hit-side latch
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      fire[k]  = close_frame & hit_q[k] & (cd_q[k] == '0);
      cd_d[k]  = cd_q[k];
      if (!run) begin
        cd_d[k] = '0;
      end else if (sof_live) begin
        if (fire[k])              cd_d[k] = CD_W'(COOLDOWN_FRAMES);
        else if (cd_q[k] != '0)   cd_d[k] = cd_q[k] - CD_W'(1);
      end
    end
    pulse_d = fire;
    side_d  = (|fire) ? side_calc : side_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      min_x_q <= '1;
      max_x_q <= '0;
      min_y_q <= '1;
      max_y_q <= '0;
      hit_q   <= '0;
      cxv_q   <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      cd_q    <= '0;
      pulse_q <= '0;
      side_q  <= 2'b00;
    end else begin
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      hit_q   <= hit_d;
      cxv_q   <= cxv_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cd_q    <= cd_d;
      pulse_q <= pulse_d;
      side_q  <= side_d;
    end
  end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Consumes the per-pixel draw-request flags that the object layers present to the video mux; it is the reader side of that draw interface.
- Watches the raster for pixels where the ball sprite overlaps a flipper, an obstacle or the play-field border.
- Accumulates those overlaps over one frame. At the next start of frame it issues one-cycle collision pulses and a hit-side code to the ball physics block.
- Provides per-kind cooldown so a resting overlap does not re-trigger every frame.

Parameters:
- COORD_W, 11, width of pixelX/pixelY.
- COOLDOWN_FRAMES, 3, frames a collision kind stays suppressed after being reported; 0 = no suppression.
- CD_W, 4, width of each cooldown counter; must hold COOLDOWN_FRAMES.

Ports:
- clk  in  1  system clock, one pixel per cycle when pixelValid=1.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse marking the first pixel of a frame.
- pixelValid  in  1  current pixelX/pixelY and draw flags are in the active area.
- pixelX  in  COORD_W  current raster X.
- pixelY  in  COORD_W  current raster Y.
- draw_smiley  in  1  ball sprite covers this pixel.
- draw_flipper  in  1  flipper covers this pixel.
- drawObstacle  in  1  obstacle covers this pixel.
- drawBorder  in  1  play-field border covers this pixel.
- collisionFlipper  out  1  one-cycle pulse: ball/flipper overlap in the previous frame.
- collisionObstacle  out  1  one-cycle pulse: ball/obstacle overlap in the previous frame.
- collisionBorder  out  1  one-cycle pulse: ball/border overlap in the previous frame.
- hitSide  out  2  side of the ball hit; 00 top, 01 bottom, 10 left, 11 right. Held until the next report.

Behaviour:
- Reset, clk and resetN: reset resetN, asynchronous, active-low; clock clk.
- Reset values: all pulses 0, hitSide 00, state WAIT_SOF, accumulators cleared, cooldown counters 0.
- States:
  - WAIT_SOF: entered from reset; ignores pixels until the first startOfFrame, then goes to ACCUM.
  - ACCUM: on each cycle with pixelValid=1, updates state as follows.
    - Ball bounding box: minX/maxX/minY/maxY updated whenever draw_smiley=1.
    - Overlap flags: hitF, hitO, hitB set when draw_smiley is 1 together with the matching object flag.
    - Collision point: the first overlap pixel of the frame is latched as (cx,cy). Priority within a single pixel is flipper > obstacle > border. Once cxValid=1, later overlaps do not move (cx,cy).
  - REPORT: a single cycle entered on startOfFrame while in ACCUM.
- Report cycle (the cycle after startOfFrame is sampled):
  - Each collisionX pulses 1 iff its hit flag was set and that kind's cooldown counter is 0.
  - A pulsing kind loads its cooldown counter with COOLDOWN_FRAMES. Every nonzero counter decrements by 1 at each startOfFrame.
  - hitSide is updated only if at least one pulse fires. Computation:
    - Centre cxC = (minX+maxX)>>1, cyC = (minY+maxY)>>1, summed at COORD_W+1 bits.
    - dx = cx-cxC, dy = cy-cyC as signed COORD_W+1 values.
    - If |dy| >= |dx|: top if dy<0, else bottom. Otherwise: left if dx<0, else right.
- Latency: pulses appear exactly 1 cycle after the startOfFrame that closes the frame.
- Frame ownership: the pixel presented in the same cycle as startOfFrame belongs to the NEW frame. Accumulators clear and that pixel is accumulated into the fresh frame in the same cycle.
- No ball drawn in a frame: bounding box stays invalid and no flags are set, so no pulses.
- Pixels with pixelValid=0 are ignored entirely.
- Back-to-back startOfFrame pulses: the second closes an empty frame, so no pulses, but cooldowns still decrement.
- Reset mid-frame: all state is lost; nothing is reported until a full frame completes after the next startOfFrame.
- Cooldown decrements saturate at 0. A kind that is still overlapping while its counter is nonzero is discarded, not deferred.

Optional Feature:
- Macro COLLISION_START_GATE_EN.
- When defined: adds input port start (1 bit, game-running flag from the welcome-screen logic).
  - While start=0, accumulation is suppressed, all pulses are forced to 0, cooldown counters are held at 0 and the state is forced to WAIT_SOF.
  - When start rises, detection resumes at the next startOfFrame.
- When undefined: no start port; detection always runs.

Test Plan:
- Ball box X 100..115, Y 200..215. Flipper overlap only at (108,215). Then SOF -> collisionFlipper=1 for exactly 1 cycle after SOF, hitSide=01, other pulses 0.
- Same ball; obstacle overlap at (100,207) and border overlap at (115,207) in one frame -> collisionObstacle=1 and collisionBorder=1 in the same cycle. hitSide=10, because (100,207) is the first overlap in raster order.
- Flipper overlap repeated for 5 consecutive frames, COOLDOWN_FRAMES=3 -> collisionFlipper pulses after frame 1 and frame 5 only.
- Overlap pixel presented in the same cycle as SOF -> no pulse at that SOF; pulse at the following SOF.
- resetN asserted mid-frame after an overlap -> outputs 0 immediately. Pixels before the first SOF after release are ignored. First report only after a complete frame.
- With COLLISION_START_GATE_EN, start=0 and overlap present -> no pulses. Raise start -> pulse one frame after the next SOF.
